// File: rtl/mask_pixel_source.sv
// Frame pixel source: fetches image pixels and mask bits from frame memory,
// applies the selected mask operation and buffers results in a small
// first-word-fall-through FIFO that the VGA driver drains one pixel per pix_rd.
module mask_pixel_source #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [1:0]        mode,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       img_data,
  input  logic              mask_bit,
  input  logic              pix_rd,
  output logic [11:0]       pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              frame_done
);

  localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned POP_W = $clog2(TOTAL + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [POP_W-1:0]  LAST_POP  = POP_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic [1:0]        mode_q;
  logic [11:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [POP_W-1:0]  pop_cnt_q;
  logic              underflow_q;
  logic              frame_done_q;

  logic [11:0] masked;
  logic        do_pop;
  logic        do_write;

  // Credit rule: an outstanding read already owns a FIFO slot.
  always_comb begin
    mem_en   = (state_q == StFetch) && ((count_q + CNT_W'(inflight_q)) < DEPTH_C);
    mem_addr = addr_q;
    do_write = inflight_q;
    do_pop   = pix_rd && (count_q != '0);
  end

  // Mask operation on returning memory data.
  always_comb begin
    masked = img_data;
    case (mode_q)
      2'b00:   masked = img_data;
      2'b01:   masked = mask_bit ? img_data : 12'h000;
      2'b10:   masked = mask_bit ? img_data : ~img_data;
      default: masked = mask_bit ? img_data
                                 : {1'b0, img_data[11:9], 1'b0, img_data[7:5],
                                    1'b0, img_data[3:1]};
    endcase
  end

  // Fall-through head; reads as zero while empty.
  always_comb begin
    pix_valid  = (count_q != '0);
    pix_data   = pix_valid ? fifo_q[rd_ptr_q] : 12'h000;
    underflow  = underflow_q;
    frame_done = frame_done_q;
  end

  // FIFO storage; pointers decide what is live, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_write) begin
      fifo_q[wr_ptr_q] <= masked;
    end
  end

  // Fetch FSM, FIFO bookkeeping, pop counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      mode_q       <= 2'b00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pop_cnt_q    <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (frame_start) begin
      // Restart: flush, and drop any read whose data is still returning.
      state_q      <= StFetch;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      mode_q       <= mode;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pop_cnt_q    <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      inflight_q <= mem_en;
      if (mem_en) begin
        if (addr_q == LAST_ADDR) begin
          state_q <= StDone;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        pop_cnt_q <= pop_cnt_q + POP_W'(1);
      end
      case ({do_write, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (pix_rd && (count_q == '0)) begin
        underflow_q <= 1'b1;
      end
      frame_done_q <= do_pop && (pop_cnt_q == LAST_POP);
    end
  end

endmodule

// File: tb/tb_mask_pixel_source.sv
// Bench for mask_pixel_source: small 4x2 frame, 4-entry FIFO, a memory model
// answering strobes one cycle later, and a reference pixel queue per frame.
module tb_mask_pixel_source;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int D     = 4;
  localparam int AW    = 3;
  localparam int TOTAL = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [1:0]    mode;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [11:0]   img_data;
  logic          mask_bit;
  logic          pix_rd;
  logic [11:0]   pix_data;
  logic          pix_valid;
  logic          underflow;
  logic          frame_done;

  always #5 clk = ~clk;

  mask_pixel_source #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .ADDR_W    (AW),
    .FIFO_DEPTH(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .mode       (mode),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .img_data   (img_data),
    .mask_bit   (mask_bit),
    .pix_rd     (pix_rd),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .underflow  (underflow),
    .frame_done (frame_done)
  );

  logic [11:0] img [TOTAL];
  logic        msk [TOTAL];
  int          strobes [$];

  // Frame memory: data valid the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en) begin
      img_data <= img[mem_addr];
      mask_bit <= msk[mem_addr];
      if (!rst) strobes.push_back(int'(mem_addr));
    end else begin
      img_data <= 12'hBAD;
      mask_bit <= 1'($urandom);
    end
  end

  logic [11:0] exp_q [$];
  int          pops;
  bit          fd_next;
  bit          uf_exp;
  int          n_total = 0;
  int          n_pass  = 0;

  function automatic logic [11:0] ref_pix(input logic [11:0] p, input logic m,
                                          input logic [1:0] md);
    int r, g, b;
    r = int'(p[11:8]);
    g = int'(p[7:4]);
    b = int'(p[3:0]);
    if (m || md == 2'd0) return p;
    if (md == 2'd1) return 12'h000;
    if (md == 2'd2) return 12'hFFF - p;
    return {4'(r / 2), 4'(g / 2), 4'(b / 2)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] m);
    frame_start = 1'b1;
    mode        = m;
    pix_rd      = 1'b0;
    tick();
    frame_start = 1'b0;
    mode        = 2'($urandom);
    strobes.delete();
    exp_q.delete();
    for (int i = 0; i < TOTAL; i++) exp_q.push_back(ref_pix(img[i], msk[i], m));
    pops    = 0;
    fd_next = 1'b0;
    uf_exp  = 1'b0;
  endtask

  // Random driver pops; each cycle checks flags, empty output and popped pixels.
  task automatic drain(input int cycles, input int pct, input bit allow_uf);
    for (int c = 0; c < cycles; c++) begin
      check("frame_done", frame_done, fd_next);
      check("underflow", underflow, uf_exp);
      check("fifo_bound", dut.count_q <= D, 1);
      if (!pix_valid) check("pix_data_empty", pix_data, 0);
      pix_rd = (pops < TOTAL) && ($urandom_range(99) < pct) && (allow_uf || pix_valid);
      fd_next = 1'b0;
      if (pix_rd) begin
        if (pix_valid) begin
          check("pix_data", pix_data, exp_q.pop_front());
          pops++;
          fd_next = (pops == TOTAL);
        end else begin
          uf_exp = 1'b1;
        end
      end
      tick();
    end
    pix_rd = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < TOTAL; i++) begin
      img[i] = 12'h100 + 12'(i);
      msk[i] = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; mode = 2'b00; pix_rd = 1'b0;
    load_ramp();
    tick(); tick();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_underflow", underflow, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    tick();

    // No pops: credit limit allows exactly D strobes.
    start_frame(2'b00);
    check("t1_first_strobe", mem_en, 1);
    check("t1_first_addr", mem_addr, 0);
    check("t1_not_valid_yet", pix_valid, 0);
    tick(); tick();
    check("t1_valid_at_2", pix_valid, 1);
    check("t1_head", pix_data, 12'h100);
    repeat (8) tick();
    check("t1_strobe_count", strobes.size(), D);
    for (int k = 0; k < strobes.size(); k++) check("t1_strobe_addr", strobes[k], k);
    check("t1_mem_en_idle", mem_en, 0);

    // Continuous drain once valid: whole frame, single frame_done.
    start_frame(2'b00);
    for (int i = 0; i < 10 && !pix_valid; i++) tick();
    check("t2_valid_seen", pix_valid, 1);
    drain(20, 100, 1'b0);
    check("t2_frame_done_end", frame_done, fd_next);
    check("t2_pops", pops, TOTAL);
    check("t2_strobes", strobes.size(), TOTAL);
    check("t2_done_no_strobe", mem_en, 0);
    check("t2_underflow", underflow, 0);
    check("t2_empty", pix_valid, 0);

    // Mask modes on an alternating mask.
    for (int i = 0; i < TOTAL; i++) begin
      img[i] = 12'hF84;
      msk[i] = (i % 2 == 0);
    end
    for (int md = 1; md < 4; md++) begin
      start_frame(2'(md));
      drain(60, 60, 1'b0);
      check("t3_pops", pops, TOTAL);
    end

    // Random images, masks, modes and pop timing (early pops allowed).
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < TOTAL; i++) begin
        img[i] = 12'($urandom);
        msk[i] = 1'($urandom);
      end
      start_frame(2'($urandom));
      drain(80, 50, 1'b1);
      check("rand_pops", pops, TOTAL);
    end

    // Pop on empty right after restart: sticky underflow, no pointer move.
    load_ramp();
    start_frame(2'b00);
    drain(1, 100, 1'b1);
    drain(60, 60, 1'b0);
    check("t4_pops", pops, TOTAL);
    check("t4_sticky", underflow, 1);

    // Restart clears underflow; then restart with 3 buffered and 1 in flight.
    start_frame(2'b00);
    check("t4_cleared", underflow, 0);
    repeat (4) tick();
    check("t5_count3", dut.count_q, 3);
    check("t5_inflight", dut.inflight_q, 1);
    check("t5_head", pix_data, 12'h100);
    start_frame(2'b00);
    check("t5_flushed", pix_valid, 0);
    check("t5_restart_strobe", mem_en, 1);
    check("t5_restart_addr", mem_addr, 0);
    drain(40, 100, 1'b0);
    check("t5_pops", pops, TOTAL);

    // Reset mid-fetch overrides a simultaneous frame_start.
    start_frame(2'b01);
    drain(3, 100, 1'b1);
    rst = 1'b1;
    frame_start = 1'b1;
    tick();
    rst = 1'b0;
    frame_start = 1'b0;
    check("t6_mem_en", mem_en, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_pix_data", pix_data, 0);
    check("t6_pix_valid", pix_valid, 0);
    check("t6_underflow", underflow, 0);
    check("t6_frame_done", frame_done, 0);
    strobes.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_idle_no_strobe", mem_en, 0);
    end
    check("t6_strobes", strobes.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mask_pixel_source.md
Name: mask_pixel_source

Overview:
- Upstream stage of the VGA driver. Fetches image pixels and mask bits from frame memory and applies the selected masking operation.
- Buffers the results in a small first-word-fall-through FIFO and hands one 12-bit RGB444 pixel per pix_rd request to the driver during active video.
- Fetch is credit-limited so the FIFO never overflows. Draining too early is flagged as underflow.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 19, memory address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse from the driver at start of vertical blank; starts or restarts a frame fetch
- mode  in  2  mask operation; sampled only on frame_start
- mem_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  pixel index being read, row-major
- img_data  in  12  RGB444 pixel, valid exactly 1 cycle after mem_en
- mask_bit  in  1  mask bit (1 = inside mask), valid with img_data
- pix_rd  in  1  driver pops one pixel
- pix_data  out  12  FIFO head pixel
- pix_valid  out  1  FIFO non-empty
- underflow  out  1  sticky; pix_rd seen while FIFO empty
- frame_done  out  1  one-cycle pulse when last pixel of frame is popped

Behaviour:
Reset:
- mem_en=0, mem_addr=0, pix_data=0, pix_valid=0, underflow=0, frame_done=0.
- FIFO empty, mode register=00, FSM in IDLE.

FSM:
- IDLE: wait for frame_start.
- FETCH: issue reads.
- DONE: all H_ACTIVE*V_ACTIVE reads issued; wait for frame_start.

frame_start, in any state, takes effect next cycle:
- FIFO flushed; read/write pointers and count set to 0.
- Fetch address set to 0; pop counter set to 0; underflow cleared.
- mode latched.
- Any read in flight is discarded (in-flight flag cleared, returning data not written).
- FSM goes to FETCH.

Fetch (FETCH state):
- mem_en=1 in a cycle iff fifo_count + inflight < FIFO_DEPTH. inflight is 0 or 1: mem_en registered last cycle and not cancelled.
- mem_addr holds the address of the current strobe, then increments after it.
- The strobe with mem_addr = H_ACTIVE*V_ACTIVE-1 moves FSM to DONE. mem_en=0 in DONE and IDLE.

Data return:
- Data for a strobe in cycle t arrives in cycle t+1, passes through combinational mask logic, and is written to the FIFO at end of t+1.
- pix_valid rises at t+2 if the FIFO was empty. Minimum strobe-to-pix_valid latency is 2 cycles.

Mask operations (m = mask_bit, p = img_data, channel = each 4-bit field):
- 00 pass: out = p
- 01 cut: out = m ? p : 12'h000
- 10 invert-outside: out = m ? p : p ^ 12'hFFF
- 11 dim-outside: out = m ? p : each channel logically shifted right by 1 (e.g. F84 -> 742)

FIFO:
- First-word fall-through: pix_data = head entry whenever pix_valid=1, and 12'h000 when empty.
- pix_rd with pix_valid=1 pops; pix_data updates next cycle.
- Simultaneous write and pop: count unchanged, both take effect.
- Full-FIFO write cannot occur because of the credit rule. The bench asserts fifo_count <= FIFO_DEPTH.
- pix_rd while empty: no pointer change, underflow set to 1 next cycle and held until rst or frame_start.

Pop counter and frame_done:
- The pop counter counts successful pops.
- The pop that makes it reach H_ACTIVE*V_ACTIVE pulses frame_done for exactly one cycle (the cycle after the pop).
- Further pops after that only flag underflow.

Reset mid-frame: rst overrides frame_start and all activity; all state returns to reset values.

Test Plan:
1. Bench params H=4, V=2, DEPTH=4, memory img[i]=12'h100+i, mask=1, mode=00. Pulse frame_start, never pop -> exactly 4 strobes at addr 0..3, then mem_en stays 0; pix_valid=1 with pix_data=100 two cycles after the first strobe.
2. Same setup, pix_rd held high once pix_valid is seen -> pix_data sequence 100..107, all 8 addresses strobed, FSM DONE, one frame_done pulse after the 8th pop, underflow=0.
3. mask alternating 1,0 (even addresses inside), img=12'hF84 everywhere, modes 01/10/11 on three frames -> popped pixels F84,000,... / F84,07B,... / F84,742,....
4. Pop with FIFO empty right after frame_start -> underflow=1 next cycle, no pointer move; stays 1 through the frame; the next frame_start clears it.
5. frame_start asserted while a strobe is in flight with 3 entries buffered -> FIFO empty next cycle, the in-flight return is not written, the next strobe is at addr 0, and the first popped pixel is 100.
6. rst asserted mid-FETCH for one cycle -> all outputs at reset values next cycle, FSM IDLE, no mem_en until the next frame_start.
